// File: rtl/epu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : epu_pkg
// Description : Shared types and widths for the EPU weight-fetch path.
//               - wfs_state_t : weight_fetch_sched state encoding
//               - LAYER_W     : width of the layer index field
//               - CH_W        : width of the channel counters / count inputs
//               - last_index(): maps a channel count onto the last valid index
// Revision    : 1.0 - initial release
// ============================================================================
package epu_pkg;

    localparam int LAYER_W = 3;
    localparam int CH_W    = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        NEXT  = 3'd4,
        LOAD  = 3'd5
    } wfs_state_t;

    // A count of 0 behaves like 1, and counts above max_ch saturate at max_ch.
    function automatic logic [CH_W-1:0] last_index(input logic [CH_W-1:0] n,
                                                   input int              max_ch);
        if (n == '0) begin
            return '0;
        end
        if (int'(n) > max_ch) begin
            return CH_W'(max_ch - 1);
        end
        return n - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wfs_ch_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wfs_ch_cnt
// Description : Nested (output-channel outer, input-channel inner) counter
//               with wrap and last-pair detection.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               load        - capture counts, zero both counters
//               adv         - advance to the next (of, if) pair
//               if_num      - input-channel count (captured on load)
//               of_num      - output-channel count (captured on load)
//               if_ch       - current input-channel index
//               of_ch       - current output-channel index
//               last        - current pair is the final pair of the layer
// Revision    : 1.0 - initial release
// ============================================================================
module wfs_ch_cnt
    import epu_pkg::*;
#(
    parameter int MAX_CH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            adv,
    input  logic [CH_W-1:0] if_num,
    input  logic [CH_W-1:0] of_num,
    output logic [CH_W-1:0] if_ch,
    output logic [CH_W-1:0] of_ch,
    output logic            last
);

    logic [CH_W-1:0] r_last_if;
    logic [CH_W-1:0] r_last_of;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_ch     <= '0;
            of_ch     <= '0;
            r_last_if <= '0;
            r_last_of <= '0;
        end else if (load) begin
            if_ch     <= '0;
            of_ch     <= '0;
            r_last_if <= last_index(if_num, MAX_CH);
            r_last_of <= last_index(of_num, MAX_CH);
        end else if (adv) begin
            if (if_ch != r_last_if) begin
                if_ch <= if_ch + 1'b1;
            end else begin
                if_ch <= '0;
                // of_ch only moves when the inner loop wraps: the SRAM
                // controller steps its bias address on every change here.
                if (of_ch != r_last_of) begin
                    of_ch <= of_ch + 1'b1;
                end else begin
                    of_ch <= '0;
                end
            end
        end
    end

    assign last = (if_ch == r_last_if) && (of_ch == r_last_of);

endmodule
`default_nettype wire

// File: rtl/weight_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module      : weight_fetch_sched
// Description : Walks every (output-channel, input-channel) pair of a layer,
//               issues one weight-SRAM read per pair, waits for completion,
//               holds tile-valid until the compute engine acknowledges, and
//               arbitrates the SRAM between this traffic and host loads
//               (host is only granted in IDLE or between pairs).
// Options     : WFS_TIMEOUT_EN - when defined, a watchdog aborts a WAIT that
//               lasts TO_CYC cycles and raises the sticky o_err.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_start            - begin a layer (IDLE only)
//               i_layer            - layer index (captured on start)
//               i_if_num, i_of_num - channel counts (captured on start)
//               i_read_done        - SRAM read completion pulse
//               i_tile_ack         - compute engine consumed the tile
//               i_sys_req          - host requests the SRAM (level)
//               o_sys_gnt          - host owns the SRAM
//               o_read             - one-cycle read request
//               o_layer, o_if_channel, o_of_channel - request fields
//               o_tile_valid       - current pair is in the buffer
//               o_busy             - not IDLE
//               o_layer_done       - layer finished (or aborted) pulse
//               o_err              - sticky watchdog error
// Revision    : 1.0 - initial release
// ============================================================================
module weight_fetch_sched
    import epu_pkg::*;
#(
    parameter int MAX_CH = 16,
    parameter int TO_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [LAYER_W-1:0] i_layer,
    input  logic [CH_W-1:0]    i_if_num,
    input  logic [CH_W-1:0]    i_of_num,
    input  logic               i_read_done,
    input  logic               i_tile_ack,
    input  logic               i_sys_req,
    output logic               o_sys_gnt,
    output logic               o_read,
    output logic [LAYER_W-1:0] o_layer,
    output logic [CH_W-1:0]    o_if_channel,
    output logic [CH_W-1:0]    o_of_channel,
    output logic               o_tile_valid,
    output logic               o_busy,
    output logic               o_layer_done,
    output logic               o_err
);

    wfs_state_t r_state;
    wfs_state_t w_nxt;
    logic       w_load;
    logic       w_adv;
    logic       w_done;
    logic       w_last;
    logic       w_wd_expired;
    logic       r_active;   // a layer is in progress (possibly suspended in LOAD)

    wfs_ch_cnt #(
        .MAX_CH (MAX_CH)
    ) u_ch_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .adv    (w_adv),
        .if_num (i_if_num),
        .of_num (i_of_num),
        .if_ch  (o_if_channel),
        .of_ch  (o_of_channel),
        .last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt  = r_state;
        w_load = 1'b0;
        w_adv  = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Host wins a same-cycle tie; the start is dropped.
                if (i_sys_req) begin
                    w_nxt = LOAD;
                end else if (i_start) begin
                    w_nxt  = ISSUE;
                    w_load = 1'b1;
                end
            end
            ISSUE: begin
                w_nxt = WAIT;
            end
            WAIT: begin
                if (i_read_done) begin
                    w_nxt = HOLD;
                end else if (w_wd_expired) begin
                    w_nxt  = IDLE;
                    w_done = 1'b1;
                end
            end
            HOLD: begin
                if (i_tile_ack) begin
                    w_nxt = NEXT;
                end
            end
            NEXT: begin
                // Counters advance even when the host pre-empts, so the
                // suspended ISSUE resumes on the correct pair after LOAD.
                if (w_last) begin
                    w_done = 1'b1;
                    w_nxt  = i_sys_req ? LOAD : IDLE;
                end else begin
                    w_adv = 1'b1;
                    w_nxt = i_sys_req ? LOAD : ISSUE;
                end
            end
            LOAD: begin
                if (!i_sys_req) begin
                    w_nxt = r_active ? ISSUE : IDLE;
                end
            end
            default: begin
                w_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_read       <= 1'b0;
            o_tile_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_sys_gnt    <= 1'b0;
            o_layer_done <= 1'b0;
            o_layer      <= '0;
            r_active     <= 1'b0;
        end else begin
            o_read       <= (w_nxt == ISSUE);
            o_tile_valid <= (w_nxt == HOLD);
            o_busy       <= (w_nxt != IDLE);
            o_sys_gnt    <= (w_nxt == LOAD);
            o_layer_done <= w_done;
            if (w_load) begin
                o_layer <= i_layer;
            end
            if (w_load) begin
                r_active <= 1'b1;
            end else if (w_done) begin
                r_active <= 1'b0;
            end
        end
    end

`ifdef WFS_TIMEOUT_EN
    localparam int WD_W = $clog2(TO_CYC) + 1;

    logic [WD_W-1:0] r_wd;
    logic            r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd <= (r_state == WAIT) ? r_wd + 1'b1 : '0;
            if ((r_state == WAIT) && !i_read_done && w_wd_expired) begin
                r_err <= 1'b1;
            end
        end
    end

    // r_wd counts completed WAIT cycles; this is the TO_CYC-th WAIT cycle.
    assign w_wd_expired = (r_state == WAIT) && (r_wd == WD_W'(TO_CYC - 1));
    assign o_err        = r_err;
`else
    assign w_wd_expired = 1'b0;
    assign o_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_fetch_sched
// Description : Self-checking bench for weight_fetch_sched. Expected request
//               tuples are queued when a layer is started and popped as the
//               DUT issues reads; a responder models the SRAM controller
//               (read_done 5 cycles after a read) and the compute engine
//               (ack in the same cycle tile-valid rises).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [2:0] i_layer;
    logic [4:0] i_if_num;
    logic [4:0] i_of_num;
    logic       i_read_done;
    logic       i_tile_ack;
    logic       i_sys_req;
    logic       o_sys_gnt;
    logic       o_read;
    logic [2:0] o_layer;
    logic [4:0] o_if_channel;
    logic [4:0] o_of_channel;
    logic       o_tile_valid;
    logic       o_busy;
    logic       o_layer_done;
    logic       o_err;

    always #5 clk = ~clk;

    weight_fetch_sched #(
        .MAX_CH (16),
        .TO_CYC (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_layer      (i_layer),
        .i_if_num     (i_if_num),
        .i_of_num     (i_of_num),
        .i_read_done  (i_read_done),
        .i_tile_ack   (i_tile_ack),
        .i_sys_req    (i_sys_req),
        .o_sys_gnt    (o_sys_gnt),
        .o_read       (o_read),
        .o_layer      (o_layer),
        .o_if_channel (o_if_channel),
        .o_of_channel (o_of_channel),
        .o_tile_valid (o_tile_valid),
        .o_busy       (o_busy),
        .o_layer_done (o_layer_done),
        .o_err        (o_err)
    );

    typedef struct packed {
        logic [2:0] layer;
        logic [4:0] of_ch;
        logic [4:0] if_ch;
    } req_t;

    req_t exp_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int n_reads    = 0;
    int n_done     = 0;
    int of_changes = 0;
    int ack_cyc    = -100;
    int gnt_cyc    = -100;
    int read_cyc   = 0;
    int done_cyc   = 0;
    int rd_cnt     = -1;
    int rd0        = 0;
    int dn0        = 0;
    bit rd_en      = 1'b1;
    bit ack_en     = 1'b1;
    bit lat_chk    = 1'b1;
    bit rd_prev    = 1'b0;
    logic       prev_busy = 1'b0;
    logic       prev_gnt  = 1'b0;
    logic [4:0] prev_of   = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor + responder: samples on the falling edge, drives responses there.
    initial begin
        i_read_done = 1'b0;
        i_tile_ack  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rd_cnt      = -1;
                i_read_done = 1'b0;
                i_tile_ack  = 1'b0;
                rd_prev     = 1'b0;
                prev_busy   = 1'b0;
                prev_gnt    = 1'b0;
                prev_of     = o_of_channel;
                continue;
            end
            if (rd_prev) begin
                check_eq("read_done_to_tile_valid", 32'(o_tile_valid), 1);
            end
            if (lat_chk && (cyc - ack_cyc == 2) && (exp_q.size() != 0)) begin
                check_eq("ack_to_next_read", 32'(o_read), 1);
            end
            if (o_read) begin
                n_reads++;
                read_cyc = cyc;
                check_eq("read_expected", 32'(exp_q.size() != 0), 1);
                check_eq("read_while_gnt", 32'(o_sys_gnt), 0);
                if (exp_q.size() != 0) begin
                    req_t e;
                    e = exp_q.pop_front();
                    check_eq("req_fields", 32'({o_layer, o_of_channel, o_if_channel}), 32'(e));
                end
            end
            if (o_layer_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (o_sys_gnt && !prev_gnt) begin
                gnt_cyc = cyc;
            end
            if (prev_busy && o_busy && (o_of_channel != prev_of)) begin
                of_changes++;
            end
            prev_busy = o_busy;
            prev_gnt  = o_sys_gnt;
            prev_of   = o_of_channel;

            i_read_done = 1'b0;
            if (o_read) begin
                rd_cnt = 4;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
            end
            if ((rd_cnt == 0) && rd_en) begin
                i_read_done = 1'b1;
                rd_cnt      = -1;
            end
            rd_prev    = i_read_done;
            i_tile_ack = ack_en && o_tile_valid;
            if (i_tile_ack) begin
                ack_cyc = cyc;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the start.
    task automatic start_layer(input logic [2:0] l, input logic [4:0] ifn, input logic [4:0] ofn);
        int   nif;
        int   nof;
        req_t e;
        nif = (ifn == 0) ? 1 : int'(ifn);
        nof = (ofn == 0) ? 1 : int'(ofn);
        for (int o = 0; o < nof; o++) begin
            for (int i = 0; i < nif; i++) begin
                e.layer = l;
                e.of_ch = 5'(o);
                e.if_ch = 5'(i);
                exp_q.push_back(e);
            end
        end
        #1;
        rd0        = n_reads;
        dn0        = n_done;
        of_changes = 0;
        i_layer    = l;
        i_if_num   = ifn;
        i_of_num   = ofn;
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check_eq("start_to_read", 32'(o_read), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!o_layer_done && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(o_layer_done), 1);
    endtask

    task automatic finish_layer(input int nif, input int nof);
        wait_done("layer_done_seen", 2000);
        check_eq("idle_at_done", 32'(o_busy), 0);
        #1;
        check_eq("read_count", 32'(n_reads - rd0), 32'(nif * nof));
        check_eq("done_count", 32'(n_done - dn0), 1);
        check_eq("of_changes", 32'(of_changes), 32'(nof - 1));
        check_eq("queue_drained", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        rst       = 1'b1;
        i_start   = 1'b0;
        i_layer   = '0;
        i_if_num  = '0;
        i_of_num  = '0;
        i_sys_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_read",       32'(o_read), 0);
        check_eq("rst_tile_valid", 32'(o_tile_valid), 0);
        check_eq("rst_busy",       32'(o_busy), 0);
        check_eq("rst_layer_done", 32'(o_layer_done), 0);
        check_eq("rst_sys_gnt",    32'(o_sys_gnt), 0);
        check_eq("rst_err",        32'(o_err), 0);
        check_eq("rst_layer",      32'(o_layer), 0);
        check_eq("rst_if_ch",      32'(o_if_channel), 0);
        check_eq("rst_of_ch",      32'(o_of_channel), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Layer 1: 1 input channel x 3 output channels.
        start_layer(3'd1, 5'd1, 5'd3);
        finish_layer(1, 3);
        repeat (3) @(negedge clk);

        // Layer 2: 2 x 2, inner loop over input channel.
        start_layer(3'd2, 5'd2, 5'd2);
        finish_layer(2, 2);
        repeat (3) @(negedge clk);

        // Zero counts behave as one.
        start_layer(3'd7, 5'd0, 5'd0);
        finish_layer(1, 1);
        repeat (3) @(negedge clk);

        // Host request raised during WAIT of pair (0,0).
        start_layer(3'd3, 5'd2, 5'd1);
        lat_chk = 1'b0;
        @(negedge clk);
        i_sys_req = 1'b1;
        k = 0;
        while (!o_sys_gnt && (k < 100)) begin
            @(negedge clk);
            k++;
        end
        check_eq("preempt_gnt_seen", 32'(o_sys_gnt), 1);
        check_eq("preempt_busy", 32'(o_busy), 1);
        check_eq("preempt_no_tile", 32'(o_tile_valid), 0);
        #1;
        check_eq("gnt_after_next", 32'(gnt_cyc - ack_cyc), 2);
        repeat (4) @(negedge clk);
        check_eq("gnt_held", 32'(o_sys_gnt), 1);
        i_sys_req = 1'b0;
        @(negedge clk);
        check_eq("gnt_release", 32'(o_sys_gnt), 0);
        check_eq("resume_read", 32'(o_read), 1);
        finish_layer(2, 1);
        lat_chk = 1'b1;
        repeat (3) @(negedge clk);

        // Start and host request in the same IDLE cycle: host wins.
        #1;
        rd0       = n_reads;
        i_layer   = 3'd6;
        i_if_num  = 5'd1;
        i_of_num  = 5'd1;
        i_start   = 1'b1;
        i_sys_req = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check_eq("tie_gnt",  32'(o_sys_gnt), 1);
        check_eq("tie_read", 32'(o_read), 0);
        check_eq("tie_busy", 32'(o_busy), 1);
        repeat (2) @(negedge clk);
        i_sys_req = 1'b0;
        @(negedge clk);
        check_eq("tie_gnt_drop", 32'(o_sys_gnt), 0);
        check_eq("tie_idle", 32'(o_busy), 0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("tie_no_read", 32'(n_reads - rd0), 0);

        // Reset while holding a tile.
        @(negedge clk);
        ack_en = 1'b0;
        start_layer(3'd4, 5'd1, 5'd2);
        k = 0;
        while (!o_tile_valid && (k < 50)) begin
            @(negedge clk);
            k++;
        end
        check_eq("hold_reached", 32'(o_tile_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_in_hold_outputs",
                 32'({o_read, o_tile_valid, o_busy, o_layer_done, o_sys_gnt, o_err,
                      o_layer, o_if_channel, o_of_channel}), 0);
        exp_q.delete();
        rst    = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        start_layer(3'd5, 5'd3, 5'd1);
        finish_layer(3, 1);
        repeat (3) @(negedge clk);

`ifdef WFS_TIMEOUT_EN
        // Read completion withheld: watchdog aborts after 64 WAIT cycles.
        rd_en = 1'b0;
        start_layer(3'd6, 5'd1, 5'd1);
        wait_done("timeout_done_seen", 200);
        check_eq("timeout_err", 32'(o_err), 1);
        check_eq("timeout_idle", 32'(o_busy), 0);
        #1;
        check_eq("timeout_latency", 32'(done_cyc - read_cyc), 65);
        exp_q.delete();
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
`else
        check_eq("err_tied_low", 32'(o_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
